halftone_stream_converter: RTL and testbench

- Streaming, parametrised successor to the fixed 8x6, 4-processor halftone converter.
- Accepts greyscale pixels in raster order over a valid/ready handshake.
- Applies error diffusion with weights 2/8/4/2 (left / up-left / up / up-right, sum >>4), thresholds each pixel and emits one halftone bit per pixel with frame markers.
- Previous-row errors live in an internal line buffer, so image size is set only by parameters, not by a hard-coded schedule.

---
 rtl/halftone_stream_converter.sv | 185 ++++++++++++++++++
 tb/tb_halftone_stream_converter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/halftone_stream_converter.sv
// Streaming error-diffusion halftoner: raster pixels in, one thresholded bit per pixel out.
// Define HT_WHITE_COUNT_EN to add white_cnt_o, a per-frame count of emitted white bits.
module halftone_stream_converter #(
  parameter int PIXEL_W = 8,
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 6,
  parameter int THRESH  = 128,
  parameter int W_L     = 2,
  parameter int W_UL    = 8,
  parameter int W_U     = 4,
  parameter int W_UR    = 2,
  parameter int W_SHIFT = 4
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               pix_valid_i,
  output logic               pix_ready_o,
  input  logic [PIXEL_W-1:0] pix_data_i,
  output logic               ht_valid_o,
  input  logic               ht_ready_i,
  output logic               ht_bit_o,
  output logic               ht_sof_o,
  output logic               ht_eol_o,
  output logic               ht_eof_o,
  output logic               busy_o,
  output logic               done_o
`ifdef HT_WHITE_COUNT_EN
  ,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0] white_cnt_o
`endif
);

  localparam int EW   = PIXEL_W + 2;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int MAXV = (2 ** PIXEL_W) - 1;
  localparam int EMAX = (2 ** (EW - 1)) - 1;
  localparam int EMIN = -(2 ** (EW - 1));

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         col_reg;
  logic [RW-1:0]         row_reg;
  logic signed [EW-1:0]  left_reg;
  logic signed [EW-1:0]  ul_reg;
  logic                  eof_acc_reg;
  logic                  valid_reg, bit_reg, sof_reg, eol_reg, eof_reg;

  logic signed [EW-1:0]  line_buf [IMG_W];

  logic                  accept, start_run;
  logic                  first_col, last_col, first_row, last_row;
  logic [CW-1:0]         col_up;
  logic signed [EW-1:0]  eu_raw, eur_raw;
  logic signed [EW-1:0]  e_l, e_ul, e_u, e_ur;
  logic signed [31:0]    e_sum, cpv, err_full;
  logic                  bit_c;
  logic signed [EW-1:0]  err_sat;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    pix_ready_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state_reg)
      IDLE: if (start_i) state_next = RUN;
      RUN: begin
        busy_o      = 1'b1;
        pix_ready_o = (!valid_reg || ht_ready_i) && !eof_acc_reg;
        if (valid_reg && ht_ready_i && eof_reg) state_next = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept    = pix_valid_i && pix_ready_o;
  assign start_run = (state_reg == IDLE) && start_i;

  assign first_col = (col_reg == '0);
  assign last_col  = (col_reg == CW'(IMG_W - 1));
  assign first_row = (row_reg == '0);
  assign last_row  = (row_reg == RW'(IMG_H - 1));

  // Up-right tap is unused on the last column, so clamp its address in range.
  assign col_up  = last_col ? col_reg : col_reg + CW'(1);
  assign eu_raw  = line_buf[col_reg];
  assign eur_raw = line_buf[col_up];

  assign e_l  = first_col                ? '0 : left_reg;
  assign e_ul = (first_col || first_row) ? '0 : ul_reg;
  assign e_u  = first_row                ? '0 : eu_raw;
  assign e_ur = (first_row || last_col)  ? '0 : eur_raw;

  assign e_sum = (W_L  * 32'(e_l) + W_UL * 32'(e_ul) +
                  W_U  * 32'(e_u) + W_UR * 32'(e_ur)) >>> W_SHIFT;
  assign cpv      = $signed(32'(pix_data_i)) + e_sum;
  assign bit_c    = (cpv >= THRESH);
  assign err_full = cpv - (bit_c ? MAXV : 0);

  always_comb begin
    err_sat = EW'(err_full);
    if (err_full > EMAX)      err_sat = EW'(EMAX);
    else if (err_full < EMIN) err_sat = EW'(EMIN);
  end

  // Contents are don't-care after reset; row 0 masks every read.
  always_ff @(posedge clk_i) begin
    if (accept) line_buf[col_reg] <= err_sat;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      col_reg     <= '0;
      row_reg     <= '0;
      left_reg    <= '0;
      ul_reg      <= '0;
      eof_acc_reg <= 1'b0;
      valid_reg   <= 1'b0;
      bit_reg     <= 1'b0;
      sof_reg     <= 1'b0;
      eol_reg     <= 1'b0;
      eof_reg     <= 1'b0;
    end else begin
      if (start_run) begin
        col_reg     <= '0;
        row_reg     <= '0;
        left_reg    <= '0;
        ul_reg      <= '0;
        eof_acc_reg <= 1'b0;
      end else if (accept) begin
        left_reg <= err_sat;
        // Old row-(r-1) value of this column becomes next pixel's up-left tap.
        ul_reg   <= eu_raw;
        if (last_col) begin
          col_reg <= '0;
          row_reg <= last_row ? '0 : row_reg + RW'(1);
        end else begin
          col_reg <= col_reg + CW'(1);
        end
        eof_acc_reg <= last_col && last_row;
      end

      if (accept) begin
        valid_reg <= 1'b1;
        bit_reg   <= bit_c;
        sof_reg   <= first_col && first_row;
        eol_reg   <= last_col;
        eof_reg   <= last_col && last_row;
      end else if (ht_ready_i) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign ht_valid_o = valid_reg;
  assign ht_bit_o   = bit_reg;
  assign ht_sof_o   = sof_reg;
  assign ht_eol_o   = eol_reg;
  assign ht_eof_o   = eof_reg;

`ifdef HT_WHITE_COUNT_EN
  localparam int WCW = $clog2(IMG_W * IMG_H + 1);
  logic [WCW-1:0] white_cnt_reg;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)                                   white_cnt_reg <= '0;
    else if (start_run)                           white_cnt_reg <= '0;
    else if (valid_reg && ht_ready_i && bit_reg)  white_cnt_reg <= white_cnt_reg + WCW'(1);
  end

  assign white_cnt_o = white_cnt_reg;
`endif

endmodule

// File: tb/tb_halftone_stream_converter.sv
// Self-checking bench for halftone_stream_converter: default 8x6 instance plus a 16x1 instance,
// both checked against a plain-arithmetic error-diffusion model.
`timescale 1ns/1ps
module tb_halftone_stream_converter;
  localparam int AW = 8;
  localparam int AH = 6;
  localparam int AN = AW * AH;
  localparam int BW = 16;
  localparam int BH = 1;
  localparam int BN = BW * BH;

  logic clk, rst_n;
  logic start_a, pv_a, pr_a, hv_a, hr_a, hb_a, hs_a, hl_a, he_a, busy_a, done_a;
  logic [7:0] pd_a;
  logic start_b, pv_b, pr_b, hv_b, hr_b, hb_b, hs_b, hl_b, he_b, busy_b, done_b;
  logic [7:0] pd_b;
`ifdef HT_WHITE_COUNT_EN
  logic [5:0] white_a;
  logic [4:0] white_b;
`endif

  int n_cmp, n_bad;
  int g_pix [96];
  int g_bit [96];
  int g_err [96];
  int exp_a [AN];
  int exp_b [BN];
  int idx_a, idx_b, done_cnt_a, done_cnt_b, ones_a, ones_b;
  bit rand_mode;

  halftone_stream_converter dut_a (
    .clk_i(clk), .rst_n(rst_n), .start_i(start_a),
    .pix_valid_i(pv_a), .pix_ready_o(pr_a), .pix_data_i(pd_a),
    .ht_valid_o(hv_a), .ht_ready_i(hr_a), .ht_bit_o(hb_a),
    .ht_sof_o(hs_a), .ht_eol_o(hl_a), .ht_eof_o(he_a),
    .busy_o(busy_a), .done_o(done_a)
`ifdef HT_WHITE_COUNT_EN
    , .white_cnt_o(white_a)
`endif
  );

  halftone_stream_converter #(.IMG_W(BW), .IMG_H(BH)) dut_b (
    .clk_i(clk), .rst_n(rst_n), .start_i(start_b),
    .pix_valid_i(pv_b), .pix_ready_o(pr_b), .pix_data_i(pd_b),
    .ht_valid_o(hv_b), .ht_ready_i(hr_b), .ht_bit_o(hb_b),
    .ht_sof_o(hs_b), .ht_eol_o(hl_b), .ht_eof_o(he_b),
    .busy_o(busy_b), .done_o(done_b)
`ifdef HT_WHITE_COUNT_EN
    , .white_cnt_o(white_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Error diffusion straight from the rules: a full 2-D error array, no line buffer.
  task automatic golden(input int w, input int h);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int i, el, eul, eu, eur, e, cpv, b, er;
        i   = r * w + c;
        el  = (c > 0)              ? g_err[i-1]   : 0;
        eul = (r > 0 && c > 0)     ? g_err[i-w-1] : 0;
        eu  = (r > 0)              ? g_err[i-w]   : 0;
        eur = (r > 0 && c < w - 1) ? g_err[i-w+1] : 0;
        e   = (2 * el + 8 * eul + 4 * eu + 2 * eur) >>> 4;
        cpv = g_pix[i] + e;
        b   = (cpv >= 128) ? 1 : 0;
        er  = cpv - (b ? 255 : 0);
        if (er > 511)  er = 511;
        if (er < -512) er = -512;
        g_bit[i] = b;
        g_err[i] = er;
      end
    end
  endtask

  task automatic prepare_a(input int mode);
    for (int i = 0; i < AN; i++) begin
      case (mode)
        0:       g_pix[i] = 0;
        1:       g_pix[i] = 255;
        2:       g_pix[i] = 128;
        default: g_pix[i] = int'($urandom_range(0, 255));
      endcase
    end
    golden(AW, AH);
    for (int i = 0; i < AN; i++) exp_a[i] = g_bit[i];
  endtask

  function automatic int sum_a();
    int s = 0;
    for (int i = 0; i < AN; i++) s += exp_a[i];
    return s;
  endfunction

  task automatic send(input int which, input int first, input int last, input bit stall);
    for (int i = first; i < last; i++) begin
      int t;
      bit acc;
      if (stall) begin
        while ($urandom_range(0, 3) == 0) begin
          if (which == 0) pv_a = 1'b0; else pv_b = 1'b0;
          @(posedge clk); #1;
        end
      end
      if (which == 0) begin pv_a = 1'b1; pd_a = 8'(g_pix[i]); end
      else begin pv_b = 1'b1; pd_b = 8'(g_pix[i]); end
      t = 0;
      acc = 1'b0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = (which == 0) ? pr_a : pr_b;
        @(posedge clk); #1;
        t++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
    end
    if (which == 0) pv_a = 1'b0; else pv_b = 1'b0;
  endtask

  task automatic wait_done(input int which, input int d0);
    int t = 0;
    while (((which == 0) ? done_cnt_a : done_cnt_b) == d0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk((which == 0) ? "done_pulses_a" : "done_pulses_b",
        (which == 0) ? done_cnt_a : done_cnt_b, d0 + 1);
  endtask

  task automatic run_frame_a(input string name, input bit stall, input bit mid_start);
    int d0;
    idx_a = 0;
    ones_a = 0;
    d0 = done_cnt_a;
    rand_mode = stall;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("busy_after_start_a", int'(busy_a), 1);
    if (mid_start) begin
      send(0, 0, 10, stall);
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      chk("busy_after_mid_start_a", int'(busy_a), 1);
      send(0, 10, AN, stall);
    end else begin
      send(0, 0, AN, stall);
    end
    wait_done(0, d0);
    chk("bits_out_a", idx_a, AN);
    chk("busy_idle_a", int'(busy_a), 0);
`ifdef HT_WHITE_COUNT_EN
    chk("white_cnt_a", int'(white_a), sum_a());
`endif
    $display("frame %s: %0d bits, %0d white (model %0d)", name, idx_a, ones_a, sum_a());
  endtask

  task automatic compare_loop();
    bit held_a = 1'b0, eof_prev_a = 1'b0, eof_prev_b = 1'b0, eof_now;
    logic [3:0] held_val_a = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_a = 1'b0;
        eof_prev_a = 1'b0;
        eof_prev_b = 1'b0;
      end else begin
        if (held_a) begin
          chk("hold_valid_a", int'(hv_a), 1);
          chk("hold_data_a", int'({hb_a, hs_a, hl_a, he_a}), int'(held_val_a));
        end
        if (done_a) begin
          done_cnt_a++;
          chk("done_after_eof_a", int'(eof_prev_a), 1);
        end
        eof_now = 1'b0;
        if (hv_a && hr_a) begin
          if (idx_a >= AN) chk("extra_out_a", idx_a, AN - 1);
          else begin
            chk($sformatf("bit_a[%0d]", idx_a), int'(hb_a), exp_a[idx_a]);
            chk($sformatf("sof_a[%0d]", idx_a), int'(hs_a), int'(idx_a == 0));
            chk($sformatf("eol_a[%0d]", idx_a), int'(hl_a), int'(idx_a % AW == AW - 1));
            chk($sformatf("eof_a[%0d]", idx_a), int'(he_a), int'(idx_a == AN - 1));
            if (hb_a) ones_a++;
            eof_now = (idx_a == AN - 1);
            idx_a++;
          end
        end
        eof_prev_a = eof_now;
        held_a = hv_a && !hr_a;
        held_val_a = {hb_a, hs_a, hl_a, he_a};

        if (done_b) begin
          done_cnt_b++;
          chk("done_after_eof_b", int'(eof_prev_b), 1);
        end
        eof_now = 1'b0;
        if (hv_b && hr_b) begin
          if (idx_b >= BN) chk("extra_out_b", idx_b, BN - 1);
          else begin
            chk($sformatf("bit_b[%0d]", idx_b), int'(hb_b), exp_b[idx_b]);
            chk($sformatf("sof_b[%0d]", idx_b), int'(hs_b), int'(idx_b == 0));
            chk($sformatf("eol_b[%0d]", idx_b), int'(hl_b), int'(idx_b % BW == BW - 1));
            chk($sformatf("eof_b[%0d]", idx_b), int'(he_b), int'(idx_b == BN - 1));
            if (hb_b) ones_b++;
            eof_now = (idx_b == BN - 1);
            idx_b++;
          end
        end
        eof_prev_b = eof_now;
      end
    end
  endtask

  task automatic ready_loop();
    forever begin
      @(posedge clk); #1;
      hr_a = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  endtask

  initial begin
    int d0;
    n_cmp = 0; n_bad = 0;
    idx_a = 0; idx_b = 0; done_cnt_a = 0; done_cnt_b = 0; ones_a = 0; ones_b = 0;
    rand_mode = 1'b0;
    rst_n = 1'b0;
    start_a = 1'b0; pv_a = 1'b0; pd_a = '0; hr_a = 1'b1;
    start_b = 1'b0; pv_b = 1'b0; pd_b = '0; hr_b = 1'b1;
    fork
      compare_loop();
      ready_loop();
    join_none

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid_a", int'(hv_a), 0);
    chk("rst_flags_a", int'({hb_a, hs_a, hl_a, he_a}), 0);
    chk("rst_ready_a", int'(pr_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_done_a", int'(done_a), 0);
    chk("rst_outs_b", int'({hv_b, hb_b, hs_b, hl_b, he_b, pr_b, busy_b, done_b}), 0);
`ifdef HT_WHITE_COUNT_EN
    chk("rst_white_a", int'(white_a), 0);
`endif
    @(posedge clk); #1;

    prepare_a(0);
    chk("model_zero_ones", sum_a(), 0);
    run_frame_a("zeros", 1'b0, 1'b0);

    prepare_a(1);
    chk("model_255_ones", sum_a(), 48);
    chk("model_255_err", g_err[0] + g_err[9] + g_err[47], 0);
    run_frame_a("all255", 1'b0, 1'b0);

    prepare_a(2);
    chk("model_128_bit00", g_bit[0], 1);
    chk("model_128_err00", g_err[0], -127);
    chk("model_128_bit10", g_bit[1], 0);
    chk("model_128_err10", g_err[1], 112);
    chk("model_128_err20", g_err[2], -113);
    chk("model_128_err01", g_err[8], 110);
    run_frame_a("all128", 1'b0, 1'b0);

    prepare_a(3);
    run_frame_a("random_stall_midstart", 1'b1, 1'b1);

    // Reset in the middle of a frame, then a complete frame afterwards.
    prepare_a(3);
    idx_a = 0;
    d0 = done_cnt_a;
    rand_mode = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    send(0, 0, 20, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_a", int'(hv_a), 0);
    chk("midrst_flags_a", int'({hb_a, hs_a, hl_a, he_a}), 0);
    chk("midrst_ready_a", int'(pr_a), 0);
    chk("midrst_busy_a", int'(busy_a), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done_a", done_cnt_a, d0);
    chk("midrst_idle_busy_a", int'(busy_a), 0);
    prepare_a(3);
    run_frame_a("after_reset", 1'b1, 1'b0);

    // 16x1 ramp on the second instance.
    for (int i = 0; i < BN; i++) g_pix[i] = 16 * i;
    golden(BW, BH);
    chk("model_ramp_err7", g_err[7], 125);
    chk("model_ramp_bit8", g_bit[8], 1);
    chk("model_ramp_err8", g_err[8], -112);
    for (int i = 0; i < BN; i++) exp_b[i] = g_bit[i];
    idx_b = 0;
    ones_b = 0;
    d0 = done_cnt_b;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    send(1, 0, BN, 1'b0);
    wait_done(1, d0);
    chk("bits_out_b", idx_b, BN);
    $display("frame ramp16x1: %0d bits, %0d white", idx_b, ones_b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
